muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for RV32M multiply/divide operations.
- Sits beside the combinational ALU in the execute stage; the decode path routes opcode OP with funct7 = 0000001 here instead of to the ALU.
- Accepts one operation, iterates radix-2 (one bit per clock), and returns a single XLEN result with a one-cycle valid pulse.
- Drives a stall to hold the pipeline while it is busy.

Parameters:
- XLEN, 32, operand/result width; the counter is clog2(XLEN) bits wide.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  XLEN  operand A; latched on accept.
- rs2  input  XLEN  operand B; latched on accept.
- flush  input  1  abort the in-flight operation (branch mispredict or trap).
- busy  output  1  high whenever state != IDLE.
- stall  output  1  combinational: (state==CALC) | (state==IDLE & start & ~flush).
- valid  output  1  one-cycle result strobe, registered.
- result  output  XLEN  registered result; holds its value until the next completion.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE; busy=0, valid=0, result=0, counter=0; all internal accumulators cleared. Reset overrides start and flush, including mid-operation.
- States:
  - IDLE: when start & ~flush, latch rs1, rs2 and funct3.
    - Compute signs: rs1 is signed for MULH, MULHSU, DIV, REM; rs2 is signed for MULH, DIV, REM.
    - Store the operand magnitudes and the result sign.
    - If the operation is a divide with rs2==0, or signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, op DIV/REM), go to DONE with the special result precomputed.
    - Otherwise clear the counter and go to CALC.
  - CALC: perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle and increment the counter.
    - At counter==XLEN-1, take the final step and go to DONE.
  - DONE: apply the sign correction, load result, pulse valid=1 for this cycle only, and return to IDLE on the next edge.
- Latency: start accepted at edge E0 → normal operations assert valid during the cycle after edge E(XLEN+1), i.e. 33 edges for XLEN=32. Special cases assert valid after E1.
- Result selection:
  - MUL: low XLEN bits of the 2·XLEN product.
  - MULH, MULHSU, MULHU: high XLEN bits, using two's-complement of the full 2·XLEN magnitude when the product sign is negative.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
- Special cases (no iteration):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow: DIV → 0x80000000; REM → 0.
- start while busy: ignored, no queueing. The pipeline is already stalled, so the request is re-presented after valid.
- flush:
  - In CALC or DONE: return to IDLE on the next edge; valid is suppressed and result is unchanged.
  - In IDLE: blocks acceptance of a simultaneous start.
- The cycle after DONE is IDLE, so a back-to-back start there is accepted.
- stall deasserts in the DONE cycle so the writeback consumes result together with valid.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD (−3), start pulse → valid exactly 33 edges later with result=0xFFFFFFEB; stall high for 33 cycles; busy low on the next cycle.
- MULH rs1=rs2=0x80000000 → 0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF. MULHU with the same operands → 0xFFFFFFFE.
- DIV rs1=0xFFFFFFF9 (−7), rs2=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases, valid one edge after accept:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Flush at iteration 10 of a DIV → busy=0 next cycle, no valid pulse, result keeps its prior value. A start in the following cycle completes correctly.
- rst asserted mid-CALC → next cycle IDLE with busy=valid=result=0. A start asserted while busy is ignored: exactly one valid pulse, and it carries the first operation's result.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit for the execute stage.
// One operation at a time, radix-2 (one bit per clock) shift-add multiply and
// restoring shift-subtract divide on operand magnitudes, sign fixed at the end.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   start   - operation request, sampled only while idle
//   funct3  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1     - operand A, latched on accept
//   rs2     - operand B, latched on accept
//   flush   - abort the in-flight operation; blocks a simultaneous start
//   busy    - high whenever an operation is in progress
//   stall   - combinational pipeline hold request
//   valid   - one-cycle registered result strobe
//   result  - registered result, held until the next completion
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;      // multiplicand or divisor magnitude
    logic [XLEN-1:0] hi_q, hi_d;    // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;    // multiplier / product low half / quotient
    logic            neg_q, neg_d;  // sign to apply to the selected result
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode for the accept cycle
    logic            is_div, s1_signed, s2_signed, n1, n2;
    logic [XLEN-1:0] m1, m2;
    logic            div_zero, div_ovf;

    always_comb begin
        is_div    = funct3[2];
        s1_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
        s2_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        n1        = s1_signed & rs1[XLEN-1];
        n2        = s2_signed & rs2[XLEN-1];
        m1        = n1 ? -rs1 : rs1;
        m2        = n2 ? -rs2 : rs2;
        div_zero  = is_div && (rs2 == '0);
        div_ovf   = is_div && !funct3[0] && (rs1 == SMIN) && (rs2 == '1);
    end

    // Datapath step terms
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        div_trial = {hi_q, lo_q[XLEN-1]};
        prod_s    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_s     = neg_q ? -lo_q : lo_q;
        rem_s     = neg_q ? -hi_q : hi_q;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d  = funct3;
                    cnt_d = '0;
                    // Special divides skip iteration: the answer is parked in
                    // lo (quotient) / hi (remainder) with no sign correction,
                    // so DONE selects it exactly like a computed result.
                    if (div_zero) begin
                        state_d = S_DONE;
                        neg_d   = 1'b0;
                        lo_d    = '1;
                        hi_d    = rs1;
                    end else if (div_ovf) begin
                        state_d = S_DONE;
                        neg_d   = 1'b0;
                        lo_d    = SMIN;
                        hi_d    = '0;
                    end else begin
                        state_d = S_CALC;
                        a_d     = is_div ? m2 : m1;
                        lo_d    = is_div ? m1 : m2;
                        hi_d    = '0;
                        neg_d   = (is_div && funct3[1]) ? n1 : (n1 ^ n2);
                    end
                end
            end

            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!op_q[2]) begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end else if (div_trial >= {1'b0, a_q}) begin
                        hi_d = div_trial[XLEN-1:0] - a_q;
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_trial[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                if (!flush) begin
                    valid_d = 1'b1;
                    if (!op_q[2]) begin
                        result_d = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                                        : prod_s[2*XLEN-1:XLEN];
                    end else begin
                        result_d = op_q[1] ? rem_s : quo_s;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign stall  = (state_q == S_CALC) || ((state_q == S_IDLE) && start && !flush);
    assign valid  = valid_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        valid;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_res;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .valid  (valid),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          edges;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one operation; check latency, result, stall duration and busy.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int edges, input int idx);
        int n;
        int st;
        bit seen;
        @(negedge clk);
        funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
        #1 st = int'(stall);
        @(posedge clk);
        #1 start = 1'b0;
        st += int'(stall);
        n = 0;
        seen = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                n = k;
                seen = 1'b1;
                break;
            end
            st += int'(stall);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout vec%0d: got no valid expected valid within 100 edges", idx);
        end else begin
            chk($sformatf("latency vec%0d", idx), n, edges);
            chk($sformatf("result vec%0d", idx), result, exp);
            chk($sformatf("stall_cycles vec%0d", idx), st, edges);
            chk($sformatf("busy_in_valid vec%0d", idx), {31'b0, busy}, 32'd0);
        end
        last_res = exp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
        vecs[2]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
        vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[12] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33};
        vecs[13] = '{3'b011, 32'h12345678, 32'h00000010, 32'h00000001, 33};
        vecs[14] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        vecs[15] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
        vecs[16] = '{3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1};

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy",   {31'b0, busy},  32'd0);
        chk("reset valid",  {31'b0, valid}, 32'd0);
        chk("reset stall",  {31'b0, stall}, 32'd0);
        chk("reset result", result,         32'd0);
        rst = 1'b0;

        // Consecutive entries also exercise back-to-back starts in the valid cycle.
        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].edges, i);
        end

        // Flush a DIV at iteration 10, then restart in the following cycle.
        @(negedge clk);
        funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_calc busy",   {31'b0, busy},  32'd0);
        chk("flush_calc valid",  {31'b0, valid}, 32'd0);
        chk("flush_calc result", result,         last_res);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 33, 100);

        // Flush in IDLE blocks a simultaneous start.
        @(negedge clk);
        funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1; flush = 1'b1;
        #1 chk("flush_idle stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("flush_idle busy", {31'b0, busy}, 32'd0);
        start = 1'b0; flush = 1'b0;

        // Flush in DONE suppresses valid and keeps result.
        @(negedge clk);
        funct3 = 3'b101; rs1 = 32'd5; rs2 = 32'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("flush_done busy_before", {31'b0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_done busy",   {31'b0, busy},  32'd0);
        chk("flush_done result", result,         last_res);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (valid) pulses++;
            @(posedge clk);
            #1;
        end
        chk("flush_done pulses", pulses, 32'd0);

        // Reset mid-CALC.
        @(negedge clk);
        funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_calc busy",   {31'b0, busy},  32'd0);
        chk("rst_calc valid",  {31'b0, valid}, 32'd0);
        chk("rst_calc result", result,         32'd0);
        last_res = 32'd0;

        // Start while busy is ignored: one pulse carrying the first result.
        @(negedge clk);
        funct3 = 3'b011; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk);
        #1;
        funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
        pulses = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                pulses++;
                chk("busy_start latency", k, 32'd33);
                chk("busy_start result", result, 32'hFFFFFFFE);
            end
            if (k == 20) start = 1'b0;
        end
        chk("busy_start pulses", pulses, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
